imm_gen_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational immediate mux.
- Decodes the immediate of a 32-bit RISC-V instruction into an XLEN-wide value.
- Formats: I, S, B, U, J, SHAMT and ZIMM, plus an illegal-select flag.
- Sits between fetch/decode and execute, with a valid/ready handshake, a 2-entry skid buffer, a sideband tag and a flush input.

---
 rtl/imm_gen_pipe.sv | 146 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate decoder with a 2-entry skid buffer.
// It decodes the immediate, registers it with a sideband tag and an
// illegal-select flag, and hands it on over a valid/ready handshake.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             flush_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    input  logic [31:0]      instr_in,
    input  logic [2:0]       sel_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid_out,
    input  logic             out_ready_in,
    output logic [XLEN-1:0]  imm_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             err_out
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_xlen_bad
        $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
    end

    // Every format fits in 32 bits. Positive formats carry a zero bit 31,
    // so one sign extension covers the whole immediate.
    logic signed [31:0] dec32;
    logic               dec_err;
    logic [XLEN-1:0]    dec_imm;

    // Combinational decode of the incoming instruction.
    always_comb begin
        dec32   = '0;
        dec_err = 1'b0;
        case (sel_in)
            3'd0: dec32 = {{20{instr_in[31]}}, instr_in[31:20]};
            3'd1: dec32 = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            3'd2: dec32 = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                           instr_in[30:25], instr_in[11:8], 1'b0};
            3'd3: dec32 = {instr_in[31:12], 12'h000};
            3'd4: dec32 = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                           instr_in[20], instr_in[30:21], 1'b0};
            3'd5: begin
                if (XLEN == 64) dec32 = {26'd0, instr_in[25:20]};
                else            dec32 = {27'd0, instr_in[24:20]};
            end
            3'd6: dec32 = {27'd0, instr_in[19:15]};
            default: dec_err = 1'b1;
        endcase
        dec_imm = XLEN'(dec32);
    end

    // Main entry drives the outputs; skid catches the beat accepted while main stalls.
    logic             main_vld_q, main_vld_d;
    logic [XLEN-1:0]  main_imm_q, main_imm_d;
    logic [TAG_W-1:0] main_tag_q, main_tag_d;
    logic             main_err_q, main_err_d;
    logic             skid_vld_q, skid_vld_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
    logic             skid_err_q, skid_err_d;

    logic accept;
    logic xfer;

    // Ready comes straight from a flop, so it never sees out_ready_in.
    assign in_ready_out  = ~skid_vld_q;
    assign out_valid_out = main_vld_q;
    assign imm_out       = main_imm_q;
    assign tag_out       = main_tag_q;
    assign err_out       = main_err_q;

    assign accept = in_valid_in & in_ready_out;
    assign xfer   = main_vld_q & out_ready_in;

    // Next-state for both entries: refill main from skid first, then from the input.
    always_comb begin
        main_vld_d = main_vld_q;
        main_imm_d = main_imm_q;
        main_tag_d = main_tag_q;
        main_err_d = main_err_q;
        skid_vld_d = skid_vld_q;
        skid_imm_d = skid_imm_q;
        skid_tag_d = skid_tag_q;
        skid_err_d = skid_err_q;

        if (!main_vld_q || xfer) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_imm_d = skid_imm_q;
                main_tag_d = skid_tag_q;
                main_err_d = skid_err_q;
                skid_vld_d = accept;
                if (accept) begin
                    skid_imm_d = dec_imm;
                    skid_tag_d = tag_in;
                    skid_err_d = dec_err;
                end
            end else begin
                main_vld_d = accept;
                if (accept) begin
                    main_imm_d = dec_imm;
                    main_tag_d = tag_in;
                    main_err_d = dec_err;
                end
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_imm_d = dec_imm;
            skid_tag_d = tag_in;
            skid_err_d = dec_err;
        end

        // Flush only drops valid bits; stale data is harmless once invalid.
        if (flush_in) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            main_vld_q <= 1'b0;
            main_imm_q <= '0;
            main_tag_q <= '0;
            main_err_q <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tag_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            main_imm_q <= main_imm_d;
            main_tag_q <= main_tag_d;
            main_err_q <= main_err_d;
            skid_vld_q <= skid_vld_d;
            skid_imm_q <= skid_imm_d;
            skid_tag_q <= skid_tag_d;
            skid_err_q <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed and randomised checks for imm_gen_pipe (XLEN=64 plus an XLEN=32 instance).
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [7:0]  tag_i;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] imm;
    logic [7:0]  tag_o;
    logic        err;

    logic        u_valid;
    logic        u_ready;
    logic [31:0] u_instr;
    logic [2:0]  u_sel;
    logic [7:0]  u_tag_i;
    logic        u_out_valid;
    logic        u_out_ready;
    logic [31:0] u_imm;
    logic [7:0]  u_tag_o;
    logic        u_err;

    int n_checks;
    int n_errors;

    typedef struct packed {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } beat_t;

    beat_t exp_q[$];

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .flush_in      (flush),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .instr_in      (instr),
        .sel_in        (sel),
        .tag_in        (tag_i),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .imm_out       (imm),
        .tag_out       (tag_o),
        .err_out       (err)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .flush_in      (1'b0),
        .in_valid_in   (u_valid),
        .in_ready_out  (u_ready),
        .instr_in      (u_instr),
        .sel_in        (u_sel),
        .tag_in        (u_tag_i),
        .out_valid_out (u_out_valid),
        .out_ready_in  (u_out_ready),
        .imm_out       (u_imm),
        .tag_out       (u_tag_o),
        .err_out       (u_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [2:0] s, input logic [7:0] t);
        in_valid = 1'b1;
        instr    = ins;
        sel      = s;
        tag_i    = t;
    endtask

    // I-format instruction whose immediate equals the tag (positive).
    function automatic logic [31:0] mk(input logic [7:0] t);
        return {4'h0, t, 20'h00000};
    endfunction

    // Reference decode for XLEN=64, written from the field layouts.
    function automatic beat_t ref_beat(input logic [31:0] ins, input logic [2:0] s,
                                       input logic [7:0] t);
        beat_t b;
        b.tag = t;
        b.err = 1'b0;
        case (s)
            3'd0: b.imm = 64'($signed(ins[31:20]));
            3'd1: b.imm = 64'($signed({ins[31:25], ins[11:7]}));
            3'd2: b.imm = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'd3: b.imm = 64'($signed({ins[31:12], 12'h000}));
            3'd4: b.imm = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            3'd5: b.imm = {58'd0, ins[25:20]};
            3'd6: b.imm = {59'd0, ins[19:15]};
            default: begin
                b.imm = 64'd0;
                b.err = 1'b1;
            end
        endcase
        return b;
    endfunction

    logic [31:0] s_ins [8] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3, 32'h123450B7,
                               32'h001000EF, 32'h03F0D093, 32'h03F0D093, 32'hFFFFFFFF};
    logic [2:0]  s_sel [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [63:0] s_exp [8] = '{64'hFFFFFFFFFFFFFFFF, 64'h8, 64'hFFFFFFFFFFFFFFFC,
                               64'h0000000012345000, 64'h800, 64'h3F, 64'h1, 64'h0};

    initial begin
        logic [63:0] held_imm;
        int accepted;
        int cycles;
        beat_t b;

        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        instr       = '0;
        sel         = '0;
        tag_i       = '0;
        out_ready   = 1'b0;
        u_valid     = 1'b0;
        u_instr     = '0;
        u_sel       = '0;
        u_tag_i     = '0;
        u_out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_imm", imm, 64'd0);
        check("rst_tag", 64'(tag_o), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_u_ready", 64'(u_ready), 64'd1);
        rst_n = 1'b1;

        // Streaming, one beat per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(s_ins[i], s_sel[i], 8'(i + 1));
            step();
            check($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("stream%0d_imm", i), imm, s_exp[i]);
            check($sformatf("stream%0d_tag", i), 64'(tag_o), 64'(i + 1));
            check($sformatf("stream%0d_err", i), 64'(err), (i == 7) ? 64'd1 : 64'd0);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 64'(out_valid), 64'd0);

        // XLEN=32 instance
        u_valid = 1'b1; u_instr = 32'h03F0D093; u_sel = 3'd5; u_tag_i = 8'h51;
        step();
        check("x32_shamt", 64'(u_imm), 64'h1F);
        check("x32_shamt_tag", 64'(u_tag_o), 64'h51);
        u_instr = 32'h800000B7; u_sel = 3'd3; u_tag_i = 8'h52;
        step();
        check("x32_u", 64'(u_imm), 64'h80000000);
        check("x32_u_err", 64'(u_err), 64'd0);
        u_valid = 1'b0;
        step();
        check("x32_drained", 64'(u_out_valid), 64'd0);

        // Backpressure with valid held high
        out_ready = 1'b0;
        drive(mk(8'hA), 3'd0, 8'hA);
        step();
        check("bp_a_valid", 64'(out_valid), 64'd1);
        check("bp_a_tag", 64'(tag_o), 64'hA);
        check("bp_ready_after_a", 64'(in_ready), 64'd1);
        held_imm = imm;
        drive(mk(8'hB), 3'd0, 8'hB);
        step();
        check("bp_hold1_tag", 64'(tag_o), 64'hA);
        check("bp_ready_after_b", 64'(in_ready), 64'd0);
        drive(mk(8'hC), 3'd0, 8'hC);
        step();
        check("bp_hold2_tag", 64'(tag_o), 64'hA);
        check("bp_hold2_imm", imm, held_imm);
        out_ready = 1'b1;
        #1;
        check("bp_ready_indep", 64'(in_ready), 64'd0);
        out_ready = 1'b0;
        #1;
        step();
        check("bp_hold3_imm", imm, 64'hA);
        out_ready = 1'b1;
        step();
        check("bp_rel_b_tag", 64'(tag_o), 64'hB);
        check("bp_rel_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_rel_c_tag", 64'(tag_o), 64'hC);
        check("bp_rel_c_imm", imm, 64'hC);
        drive(mk(8'hD), 3'd0, 8'hD);
        step();
        check("bp_rel_d_tag", 64'(tag_o), 64'hD);
        in_valid = 1'b0;
        step();
        check("bp_done", 64'(out_valid), 64'd0);

        // Flush with both entries held
        out_ready = 1'b0;
        drive(mk(8'h21), 3'd0, 8'h21);
        step();
        drive(mk(8'h22), 3'd0, 8'h22);
        step();
        check("fl_full_ready", 64'(in_ready), 64'd0);
        drive(mk(8'hEE), 3'd0, 8'hEE);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_ready", 64'(in_ready), 64'd1);
        drive(mk(8'hF0), 3'd0, 8'hF0);
        out_ready = 1'b1;
        step();
        check("fl_f_valid", 64'(out_valid), 64'd1);
        check("fl_f_tag", 64'(tag_o), 64'hF0);
        in_valid = 1'b0;
        step();
        check("fl_f_only", 64'(out_valid), 64'd0);

        // Flush while the block could accept: presented beat is discarded
        out_ready = 1'b0;
        drive(mk(8'h31), 3'd0, 8'h31);
        step();
        drive(mk(8'hE2), 3'd0, 8'hE2);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl2_valid", 64'(out_valid), 64'd0);
        check("fl2_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("fl2_no_e", 64'(out_valid), 64'd0);

        // Reset mid-stream with both entries full
        out_ready = 1'b0;
        drive(32'hFFFFFFFF, 3'd7, 8'h41);
        step();
        check("mr_err_set", 64'(err), 64'd1);
        drive(mk(8'h42), 3'd0, 8'h42);
        step();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_imm", imm, 64'd0);
        check("mr_tag", 64'(tag_o), 64'd0);
        check("mr_err", 64'(err), 64'd0);
        check("mr_ready", 64'(in_ready), 64'd1);
        drive(mk(8'h43), 3'd0, 8'h43);
        out_ready = 1'b1;
        step();
        check("mr_first_valid", 64'(out_valid), 64'd1);
        check("mr_first_tag", 64'(tag_o), 64'h43);
        in_valid = 1'b0;
        step();

        // Random valid/ready against a queue model
        exp_q.delete();
        accepted = 0;
        cycles   = 0;
        while (accepted < 10000 && cycles < 40000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            instr     = $urandom;
            sel       = 3'($urandom_range(0, 7));
            tag_i     = 8'(accepted);
            check("rnd_ready", 64'(in_ready), (exp_q.size() < 2) ? 64'd1 : 64'd0);
            check("rnd_valid", 64'(out_valid), (exp_q.size() > 0) ? 64'd1 : 64'd0);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                check("rnd_imm", imm, b.imm);
                check("rnd_tag", 64'(tag_o), 64'(b.tag));
                check("rnd_err", 64'(err), 64'(b.err));
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_beat(instr, sel, tag_i));
                accepted++;
            end
            step();
            cycles++;
        end
        check("rnd_budget", 64'(accepted), 64'd10000);

        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid && exp_q.size() > 0) begin
                b = exp_q.pop_front();
                check("drn_imm", imm, b.imm);
                check("drn_tag", 64'(tag_o), 64'(b.tag));
                check("drn_err", 64'(err), 64'(b.err));
            end
            step();
        end
        check("drn_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drn_out_idle", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
